hilo_div_unit: RTL and testbench
================================

# hilo_div_unit

Multi-cycle HI/LO writeback stage placed directly downstream of the 32-bit combinational signed divider. Captures DIV operands on issue, holds them stable on the divider inputs for a fixed latency, and commits Quotient→LO and Remainder→HI. Asserts `busy` so the pipeline can stall. Also services MTHI/MTLO writes and owns the divide-by-zero and overflow corner cases that the divider does not define.

## Interface
- `DIV_LAT`, default 4: cycles from issue to HI/LO commit; legal range 1–15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `op`  in  2  00 = DIV, 01 = MTHI, 10 = MTLO, 11 = reserved (ignored).
- `s_in`  in  32  dividend / MTHI/MTLO data.
- `t_in`  in  32  divisor.
- `s_div`  out  32  registered dividend driven to the divider.
- `t_div`  out  32  registered divisor driven to the divider.
- `quotient`  in  32  divider quotient.
- `remainder`  in  32  divider remainder.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  DIV in flight.
- `done`  out  1  one-cycle pulse after a DIV commit.
- `n_flag`  out  1  `lo[31]` as of the last DIV commit.
- `z_flag`  out  1  `lo == 0` as of the last DIV commit.
- `dz_flag`  out  1  last DIV had divisor 0.

## Operation
- States: IDLE and RUN; 4-bit down-counter `cnt`.
- IDLE, `start=1`, `op=00`:
  - `s_div <= s_in`, `t_div <= t_in`, `cnt <= DIV_LAT-1`, go to RUN.
  - `busy` is high in RUN.
- IDLE, `start=1`, `op=01`: `hi <= s_in`. Same for `op=10`: `lo <= s_in`.
  - Single edge; state stays IDLE; `busy` and `done` stay low.
  - Flags are unchanged.
- IDLE, `op=11`: no effect.
- RUN, `cnt != 0`: `cnt <= cnt-1`.
- RUN, `cnt == 0`: commit, go to IDLE, `done <= 1`. Commit values:
  - `t_div == 0`: `lo <= 32'hFFFFFFFF`, `hi <= s_div`, `dz_flag <= 1`.
  - `s_div == 32'h80000000` and `t_div == 32'hFFFFFFFF`: `lo <= 32'h80000000`, `hi <= 0`, `dz_flag <= 0`.
  - Otherwise: `lo <= quotient`, `hi <= remainder`, `dz_flag <= 0`.
  - In all cases `n_flag` and `z_flag` are computed from the committed `lo` value.
- `start` in RUN is ignored, whatever `op` is. Upstream must hold the instruction while `busy` is high.
- Divider arithmetic is signed two's complement with truncation toward zero. The remainder takes the sign of the dividend.
- `s_div`/`t_div` are stable for all of RUN and keep their value in IDLE.

## Timing
- Reset (asynchronous, `reset=0`): state IDLE, `cnt=0`.
  - All outputs 0: `hi`, `lo`, `s_div`, `t_div`, `busy`, `done`, `n_flag`, `z_flag`, `dz_flag`.
  - Reset mid-RUN aborts the operation; no commit occurs.
- DIV issued at edge E0:
  - `busy` is high in cycles E0+1 … E0+DIV_LAT.
  - HI/LO/flags update at edge E0+DIV_LAT.
  - `done` is high for exactly the cycle following that edge; `busy` is low in the same cycle.
- Back-to-back: a new `start` is accepted at edge E0+DIV_LAT+1 at the earliest. This holds because `start` is sampled only in IDLE.
- `DIV_LAT=1`: `busy` is high for one cycle; commit at E0+1.
- MTHI/MTLO: value visible one cycle after the edge at which it is sampled.
- `done` is a registered, non-sticky pulse.

## Test plan
- DIV 100/7, DIV_LAT=4:
  - `busy` is high for 4 cycles.
  - Then `lo=14`, `hi=2`, `done` pulses once, `n=0`, `z=0`, `dz=0`.
- DIV −7/2 (`s_in=32'hFFFFFFF9`, `t_in=2`):
  - `lo=32'hFFFFFFFD`, `hi=32'hFFFFFFFF`, `n_flag=1`.
- DIV 5/0:
  - `lo=32'hFFFFFFFF`, `hi=5`, `dz_flag=1`.
  - A following DIV 3/5 gives `lo=0`, `hi=3`, `z_flag=1`, `dz_flag=0`.
- DIV `32'h80000000` / `32'hFFFFFFFF`:
  - `lo=32'h80000000`, `hi=0`, `n_flag=1`, no X.
- Ignored issues and reset:
  - MTHI `32'hDEADBEEF` while `busy` is ignored: `hi` equals the DIV remainder after commit.
  - A later MTHI in IDLE sets `hi=32'hDEADBEEF` in 1 cycle, with flags unchanged.
  - Assert `reset` low in the 2nd RUN cycle: all outputs are 0 immediately, and no `done` appears after release.

Source files
------------

// File: rtl/hilo_div_unit.sv
// HI/LO writeback stage for a combinational signed divider: holds operands for
// DIV_LAT cycles, commits quotient/remainder, and handles MTHI/MTLO and divide corner cases.
module hilo_div_unit #(
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] s_in,
    input  logic [31:0] t_in,
    output logic [31:0] s_div,
    output logic [31:0] t_div,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        n_flag,
    output logic        z_flag,
    output logic        dz_flag
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0]  OP_DIV   = 2'b00;
    localparam logic [1:0]  OP_MTHI  = 2'b01;
    localparam logic [1:0]  OP_MTLO  = 2'b10;
    localparam logic [3:0]  CNT_INIT = 4'(DIV_LAT - 1);
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE  = 32'hFFFF_FFFF;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] s_div_s, t_div_s, hi_s, lo_s;
    logic        busy_s, done_s, n_s, z_s, dz_s;

    // Divide-by-zero and INT_MIN/-1 are undefined at the divider, so they are resolved here.
    // Result packs {dz, hi, lo}.
    function automatic logic [64:0] commit_value(
        input logic [31:0] s,
        input logic [31:0] t,
        input logic [31:0] q,
        input logic [31:0] r
    );
        logic [64:0] res;
        if (t == 32'h0000_0000) begin
            res = {1'b1, s, NEG_ONE};
        end else if ((s == INT_MIN) && (t == NEG_ONE)) begin
            res = {1'b0, 32'h0000_0000, INT_MIN};
        end else begin
            res = {1'b0, r, q};
        end
        return res;
    endfunction

    // Next-state and next-output logic for the IDLE/RUN sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        s_div_s = s_div;
        t_div_s = t_div;
        hi_s    = hi;
        lo_s    = lo;
        n_s     = n_flag;
        z_s     = z_flag;
        dz_s    = dz_flag;
        done_s  = 1'b0;
        busy_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_DIV: begin
                            s_div_s = s_in;
                            t_div_s = t_in;
                            cnt_s   = CNT_INIT;
                            state_s = RUN;
                        end
                        OP_MTHI: hi_s = s_in;
                        OP_MTLO: lo_s = s_in;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    {dz_s, hi_s, lo_s} = commit_value(s_div, t_div, quotient, remainder);
                    n_s     = lo_s[31];
                    z_s     = (lo_s == 32'h0000_0000);
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
        busy_s = (state_s == RUN);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            s_div   <= 32'h0000_0000;
            t_div   <= 32'h0000_0000;
            hi      <= 32'h0000_0000;
            lo      <= 32'h0000_0000;
            busy    <= 1'b0;
            done    <= 1'b0;
            n_flag  <= 1'b0;
            z_flag  <= 1'b0;
            dz_flag <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            s_div   <= s_div_s;
            t_div   <= t_div_s;
            hi      <= hi_s;
            lo      <= lo_s;
            busy    <= busy_s;
            done    <= done_s;
            n_flag  <= n_s;
            z_flag  <= z_s;
            dz_flag <= dz_s;
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed corner cases plus randomized
// DIV/MTHI/MTLO traffic checked against a sign-magnitude division model.
module tb_hilo_div_unit;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] s_in = 32'h0;
    logic [31:0] t_in = 32'h0;
    logic [31:0] s_div, t_div, quotient, remainder, hi, lo;
    logic        busy, done, n_flag, z_flag, dz_flag;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic        m_n = 1'b0;
    logic        m_z = 1'b0;
    logic        m_dz = 1'b0;

    hilo_div_unit #(.DIV_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .s_in(s_in), .t_in(t_in), .s_div(s_div), .t_div(t_div),
        .quotient(quotient), .remainder(remainder),
        .hi(hi), .lo(lo), .busy(busy), .done(done),
        .n_flag(n_flag), .z_flag(z_flag), .dz_flag(dz_flag)
    );

    always #5 clk = ~clk;

    // Combinational divider stand-in; undefined cases return junk the DUT must override.
    always_comb begin
        quotient  = 32'h1234_5678;
        remainder = 32'h9ABC_DEF0;
        if (t_div != 32'h0 && !(s_div == 32'h8000_0000 && t_div == 32'hFFFF_FFFF)) begin
            quotient  = $signed(s_div) / $signed(t_div);
            remainder = $signed(s_div) % $signed(t_div);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: divide magnitudes, then apply signs (truncation toward zero).
    function automatic void ref_div(input logic [31:0] s, input logic [31:0] t,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        logic [31:0] as, at, uq, ur;
        if (t == 32'h0) begin
            q = 32'hFFFF_FFFF; r = s; dz = 1'b1;
        end else begin
            as = s[31] ? -s : s;
            at = t[31] ? -t : t;
            uq = as / at;
            ur = as % at;
            q  = (s[31] ^ t[31]) ? -uq : uq;
            r  = s[31] ? -ur : ur;
            dz = 1'b0;
        end
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
        chk1({tag, " n"}, n_flag, m_n);
        chk1({tag, " z"}, z_flag, m_z);
        chk1({tag, " dz"}, dz_flag, m_dz);
    endtask

    task automatic run_div(input logic [31:0] s, input logic [31:0] t,
                           input bit noise, input string tag);
        logic [31:0] q, r;
        logic        dz;
        ref_div(s, t, q, r, dz);
        @(negedge clk);
        start = 1'b1; op = 2'b00; s_in = s; t_in = t;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            if (noise) begin
                start = 1'b1; op = 2'b01; s_in = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            chk1({tag, " busy"}, busy, 1'b1);
            chk1({tag, " done_early"}, done, 1'b0);
            chk({tag, " s_div"}, s_div, s);
            chk({tag, " t_div"}, t_div, t);
        end
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        m_lo = q; m_hi = r; m_dz = dz; m_n = q[31]; m_z = (q == 32'h0);
        chk1({tag, " busy_end"}, busy, 1'b0);
        chk1({tag, " done"}, done, 1'b1);
        chk_state(tag);
        @(negedge clk);
        chk1({tag, " done_pulse"}, done, 1'b0);
    endtask

    task automatic mt(input logic [1:0] o, input logic [31:0] d, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; s_in = d;
        @(negedge clk);
        start = 1'b0;
        if (o == 2'b01) m_hi = d;
        if (o == 2'b10) m_lo = d;
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " done"}, done, 1'b0);
        chk_state(tag);
    endtask

    initial begin
        logic [31:0] rs, rt;
        int sel;
        #12;
        chk("rst hi", hi, 32'h0); chk("rst lo", lo, 32'h0);
        chk("rst s_div", s_div, 32'h0); chk("rst t_div", t_div, 32'h0);
        chk1("rst busy", busy, 1'b0); chk1("rst done", done, 1'b0);
        chk1("rst n", n_flag, 1'b0); chk1("rst z", z_flag, 1'b0); chk1("rst dz", dz_flag, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, "div100_7");
        chk("c100 lo", lo, 32'd14); chk("c100 hi", hi, 32'd2);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "divm7_2");
        chk("cm7 lo", lo, 32'hFFFF_FFFD); chk("cm7 hi", hi, 32'hFFFF_FFFF); chk1("cm7 n", n_flag, 1'b1);
        run_div(32'd5, 32'd0, 1'b0, "div5_0");
        chk("c50 lo", lo, 32'hFFFF_FFFF); chk("c50 hi", hi, 32'd5); chk1("c50 dz", dz_flag, 1'b1);
        run_div(32'd3, 32'd5, 1'b0, "div3_5");
        chk("c35 lo", lo, 32'd0); chk("c35 hi", hi, 32'd3);
        chk1("c35 z", z_flag, 1'b1); chk1("c35 dz", dz_flag, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divovf");
        chk("covf lo", lo, 32'h8000_0000); chk("covf hi", hi, 32'h0); chk1("covf n", n_flag, 1'b1);
        run_div(32'd100, 32'd7, 1'b1, "div_noise");
        chk("cnoise hi", hi, 32'd2);
        mt(2'b01, 32'hDEAD_BEEF, "mthi");
        chk("cmthi hi", hi, 32'hDEAD_BEEF);
        mt(2'b10, 32'h0BAD_F00D, "mtlo");
        mt(2'b11, 32'h5555_5555, "reserved");

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 5);
            rs  = $urandom;
            if (sel <= 2) begin
                case ($urandom_range(0, 7))
                    0: rt = 32'h0;
                    1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
                    2, 3, 4: rt = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20))
                                                             : -32'($urandom_range(1, 20));
                    default: rt = $urandom;
                endcase
                run_div(rs, rt, sel == 2, "rnd_div");
            end else if (sel == 3) begin
                mt(2'b01, rs, "rnd_mthi");
            end else if (sel == 4) begin
                mt(2'b10, rs, "rnd_mtlo");
            end else begin
                mt(2'b11, rs, "rnd_resv");
            end
        end

        @(negedge clk);
        start = 1'b1; op = 2'b00; s_in = 32'd100; t_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk1("abort busy1", busy, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = 32'h0; m_lo = 32'h0; m_n = 1'b0; m_z = 1'b0; m_dz = 1'b0;
        chk_state("abort");
        chk("abort s_div", s_div, 32'h0); chk("abort t_div", t_div, 32'h0);
        chk1("abort busy", busy, 1'b0); chk1("abort done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            chk1("post_abort done", done, 1'b0);
            chk1("post_abort busy", busy, 1'b0);
            chk_state("post_abort");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
